// File: rtl/distributor.sv
// Routes one inbound stream to OUTPUTS per-port FIFOs by per-beat index; 1-cycle push-to-head latency, no bypass.
// in_ready drops only when the addressed FIFO is full; out-of-range beats are always accepted and counted as drops.
module distributor #(
  parameter int OUTPUTS       = 4,
  parameter int DATA_SIZE     = 8,
  parameter int DEPTH         = 2,
  parameter int DROP_CNT_SIZE = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(OUTPUTS)-1:0]    in_index,
  input  logic [DATA_SIZE-1:0]          in_data,
  output logic [OUTPUTS-1:0]            out_valid,
  input  logic [OUTPUTS-1:0]            out_ready,
  output logic [DATA_SIZE-1:0]          out_data [OUTPUTS],
  output logic [DROP_CNT_SIZE-1:0]      drop_count
);

  localparam int IDX_W = $clog2(OUTPUTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(OUTPUTS);
  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);

  logic               in_range;
  logic               sel_full;
  logic [OUTPUTS-1:0] full;
  logic [OUTPUTS-1:0] push;

  // Indices past OUTPUTS act as a sink, so they never stall the inbound stream.
  assign in_range = ({1'b0, in_index} < IDX_LIMIT);
  assign in_ready = !in_range || !sel_full;

  always_comb begin
    sel_full = 1'b0;
    push     = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      if (in_index == IDX_W'(k)) sel_full = full[k];
      push[k] = in_valid && in_range && !full[k] && (in_index == IDX_W'(k));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (in_valid && !in_range && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_port
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count;
    logic                 do_pop;

    assign do_pop       = out_valid[k] && out_ready[k];
    assign full[k]      = (count == DEPTH_C);
    assign out_valid[k] = (count != '0);
    assign out_data[k]  = mem[rd_ptr];

    // A full FIFO refuses the push even when it pops this cycle; the slot frees next cycle.
    always_ff @(posedge clock) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[k]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        if (push[k] && !do_pop)      count <= count + 1'b1;
        else if (!push[k] && do_pop) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_distributor.sv
// Scoreboard bench for distributor: OUTPUTS=3 (index 3 is a sink), DEPTH=2, 4-bit drop counter.
module tb_distributor;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_index;
  logic [7:0] in_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [7:0] out_data [3];
  logic [3:0] drop_count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [7:0] m_q [3][$];
  logic [7:0] log1 [$];
  int         m_drop = 0;
  logic       acc;

  distributor #(
    .OUTPUTS(3), .DATA_SIZE(8), .DEPTH(2), .DROP_CNT_SIZE(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rdy(input logic [1:0] idx);
    if (idx >= 2'd3) return 1'b1;
    return m_q[idx].size() != 2;
  endfunction

  // Reference queues: expected beats are queued as stimulus is accepted.
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) m_q[k].delete();
      m_drop = 0;
    end else begin
      acc = in_valid && exp_rdy(in_index);
      for (int k = 0; k < 3; k++)
        if (out_ready[k] && m_q[k].size() != 0) void'(m_q[k].pop_front());
      if (acc) begin
        if (in_index < 2'd3) m_q[in_index].push_back(in_data);
        else if (m_drop != 15) m_drop++;
      end
    end
  end

  // Monitor: compares every presented head, handshake and counter against the queues.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy(in_index)});
      chk("drop_count_mon", {28'd0, drop_count}, m_drop);
      for (int k = 0; k < 3; k++) begin
        chk("out_valid_mon", {31'd0, out_valid[k]}, {31'd0, m_q[k].size() != 0});
        if (m_q[k].size() != 0) chk("out_data_mon", {24'd0, out_data[k]}, {24'd0, m_q[k][0]});
      end
      if (out_valid[1] && out_ready[1]) log1.push_back(out_data[1]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] drain_exp [3];
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h22; drain_exp[2] = 8'h33;
    reset = 1'b1; in_valid = 1'b0; in_index = 2'd0; in_data = 8'h00; out_ready = 3'b000;

    // Reset for two cycles, then idle state
    cyc(); mon_en = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) chk("rst_out_data", {24'd0, out_data[k]}, 32'd0);
    chk("rst_drop", {28'd0, drop_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_index = 2'(i);
      #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Single route to port 2
    cyc(); in_valid = 1'b1; in_index = 2'd2; in_data = 8'hA5;
    cyc(); in_valid = 1'b0;
    @(negedge clock);
    chk("route_valid", {29'd0, out_valid}, 32'b100);
    chk("route_data", {24'd0, out_data[2]}, 32'hA5);
    cyc(); out_ready[2] = 1'b1;
    cyc(); out_ready = 3'b000;
    @(negedge clock);
    chk("route_popped", {31'd0, out_valid[2]}, 32'd0);

    // Fill port 1 and hold a third beat against backpressure
    cyc(); in_valid = 1'b1; in_index = 2'd1; in_data = 8'h11;
    cyc(); in_data = 8'h22;
    cyc(); in_data = 8'h33;
    @(negedge clock);
    chk("full_rdy1", {31'd0, in_ready}, 32'd0);
    #1 in_index = 2'd0;
    #1 chk("full_rdy0", {31'd0, in_ready}, 32'd1);
    in_index = 2'd1;
    cyc();
    @(negedge clock);
    chk("full_head", {24'd0, out_data[1]}, 32'h11);
    cyc(); out_ready[1] = 1'b1;
    cyc();
    cyc(); in_valid = 1'b0;
    cyc(); cyc(); cyc(); out_ready = 3'b000;
    chk("drain_len", log1.size(), 32'd3);
    for (int i = 0; i < 3 && i < log1.size(); i++) chk("drain_order", {24'd0, log1[i]}, {24'd0, drain_exp[i]});

    // Concurrent push and pop on port 2
    in_valid = 1'b1; in_index = 2'd2; in_data = 8'h55;
    cyc(); in_data = 8'h44; out_ready[2] = 1'b1;
    cyc(); in_valid = 1'b0; out_ready = 3'b000;
    @(negedge clock);
    chk("pp_valid", {31'd0, out_valid[2]}, 32'd1);
    chk("pp_head", {24'd0, out_data[2]}, 32'h44);
    cyc(); out_ready[2] = 1'b1;
    cyc(); out_ready = 3'b000;

    // Out-of-range index is sunk and counted, saturating at 15
    in_valid = 1'b1; in_index = 2'd3;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("drop5", {28'd0, drop_count}, 32'd5);
    chk("drop_no_valid", {29'd0, out_valid}, 32'd0);
    cyc(); in_valid = 1'b1;
    for (int i = 0; i < 16; i++) cyc();
    in_valid = 1'b0;
    @(negedge clock);
    chk("drop_sat", {28'd0, drop_count}, 32'd15);

    // Reset mid-operation with a beat presented
    cyc(); in_valid = 1'b1; in_index = 2'd0; in_data = 8'h61;
    cyc(); in_index = 2'd1; in_data = 8'h62;
    cyc(); in_index = 2'd0; in_data = 8'h63;
    cyc(); in_data = 8'h7E; reset = 1'b1;
    cyc(); reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("mid_rst_valid", {29'd0, out_valid}, 32'd0);
    chk("mid_rst_drop", {28'd0, drop_count}, 32'd0);
    for (int k = 0; k < 3; k++) chk("mid_rst_data", {24'd0, out_data[k]}, 32'd0);
    cyc(); cyc();
    @(negedge clock);
    chk("mid_rst_quiet", {29'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
